psum_drain_1x1: RTL and testbench

- Consumer end of the 1x1 PE partial-sum stream.
- Accumulates signed DWIDTH psums over one input-channel group, delimited by a valid/last beat sequence.
- Requantizes each group sum to signed int8 with round-half-up shift, optional ReLU and saturation.
- Buffers results in a 2-entry output FIFO with a valid/ready handshake towards the OFM writer.

---
 rtl/pe_pkg.sv | 16 +
 rtl/requant_sat.sv | 47 ++++
 rtl/psum_drain_1x1.sv | 143 ++++++++++++++
 tb/tb_psum_drain_1x1.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: widths, limits and types shared by the PE array and its drains.
// Ports: none (package).
package pe_pkg;
    localparam int OFM_W   = 8;
    localparam int OFM_MAX = 127;
    localparam int OFM_MIN = -128;
    localparam int PSUM_W  = 16;
    localparam int ACC_W   = 24;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } drain_state_e;

    typedef logic signed [OFM_W-1:0] ofm_t;
endpackage

// File: rtl/requant_sat.sv
// requant_sat: combinational requantization of an accumulator value.
// Adds a round-half-up bias, arithmetic right shift, optional ReLU,
// then saturates to a signed OW-bit value.
// Ports:
//   sum   - signed AW-bit accumulator value
//   shift - right-shift amount (0..23 in normal use)
//   relu  - clamp negative results to zero
//   q     - signed OW-bit saturated result
module requant_sat
    import pe_pkg::*;
#(
    parameter int AW = ACC_W,
    parameter int OW = OFM_W
) (
    input  logic signed [AW-1:0] sum,
    input  logic        [4:0]    shift,
    input  logic                 relu,
    output logic signed [OW-1:0] q
);
    // Output limits expressed at the AW+1 working width.
    localparam logic signed [AW:0] Q_MAX = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0] Q_MIN = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    logic signed [AW:0] rnd;
    logic signed [AW:0] added;
    logic signed [AW:0] r;

    always_comb begin
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = {{AW{1'b0}}, 1'b1} << (shift - 5'd1);
        end
        // One extra bit of headroom: max acc plus max bias cannot overflow.
        added = {sum[AW-1], sum} + rnd;
        r     = added >>> shift;
        if (relu && r[AW]) begin
            r = '0;
        end
        if (r > Q_MAX) begin
            q = Q_MAX[OW-1:0];
        end else if (r < Q_MIN) begin
            q = Q_MIN[OW-1:0];
        end else begin
            q = r[OW-1:0];
        end
    end
endmodule

// File: rtl/psum_drain_1x1.sv
// psum_drain_1x1: consumer end of the 1x1 PE partial-sum stream.
// Accumulates signed psums of one group (ended by psum_last), requantizes
// the group sum to OWIDTH bits and queues it in a 2-entry output FIFO.
// Ports:
//   clk, rstn              - clock, asynchronous active-low reset
//   psum_in/valid/last     - partial-sum beat stream from the PE
//   psum_ready             - drain can accept a beat
//   cfg_shift, cfg_relu    - requant settings, sampled on the last beat
//   ofm_out/valid/ready    - requantized result stream (FIFO head)
//   acc_sat                - sticky: accumulator clamped since reset
// Handshake (both streams): a transfer happens on a rising clk edge where
// valid && ready; the source holds data stable while valid && !ready, and
// ready never depends combinationally on the downstream ready.
module psum_drain_1x1
    import pe_pkg::*;
#(
    parameter int DWIDTH = PSUM_W,
    parameter int AWIDTH = ACC_W,
    parameter int OWIDTH = OFM_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic signed [DWIDTH-1:0] psum_in,
    input  logic                     psum_valid,
    input  logic                     psum_last,
    output logic                     psum_ready,
    input  logic        [4:0]        cfg_shift,
    input  logic                     cfg_relu,
    output logic signed [OWIDTH-1:0] ofm_out,
    output logic                     ofm_valid,
    input  logic                     ofm_ready,
    output logic                     acc_sat
);
    localparam logic signed [AWIDTH:0] ACC_MAX = {2'b00, {(AWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH:0] ACC_MIN = {2'b11, {(AWIDTH-1){1'b0}}};

    drain_state_e             state, state_next;
    logic signed [AWIDTH-1:0] acc, acc_next;
    logic signed [AWIDTH-1:0] base;
    logic signed [AWIDTH:0]   sum_wide;
    logic signed [AWIDTH-1:0] group_sum;
    logic                     clamp;
    logic                     accept;
    logic                     push;
    logic                     pop;
    logic signed [OWIDTH-1:0] q;

    logic signed [OWIDTH-1:0] mem [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;

    // Ready comes from the registered count only, so a pop while full
    // re-opens the input one cycle later.
    assign psum_ready = (count != 2'd2);
    assign accept     = psum_valid && psum_ready;
    assign ofm_valid  = (count != 2'd0);
    assign pop        = ofm_valid && ofm_ready;
    assign ofm_out    = mem[rd_ptr];

    // Saturating add; a new group starts from zero.
    always_comb begin
        base     = (state == ACCUM) ? acc : '0;
        sum_wide = {base[AWIDTH-1], base}
                 + {{(AWIDTH+1-DWIDTH){psum_in[DWIDTH-1]}}, psum_in};
        clamp    = 1'b0;
        if (sum_wide > ACC_MAX) begin
            group_sum = ACC_MAX[AWIDTH-1:0];
            clamp     = 1'b1;
        end else if (sum_wide < ACC_MIN) begin
            group_sum = ACC_MIN[AWIDTH-1:0];
            clamp     = 1'b1;
        end else begin
            group_sum = sum_wide[AWIDTH-1:0];
        end
    end

    // Next-state / datapath control.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        push       = 1'b0;
        if (accept) begin
            if (psum_last) begin
                push       = 1'b1;
                acc_next   = '0;
                state_next = IDLE;
            end else begin
                acc_next   = group_sum;
                state_next = ACCUM;
            end
        end
    end

    requant_sat #(
        .AW (AWIDTH),
        .OW (OWIDTH)
    ) u_requant (
        .sum   (group_sum),
        .shift (cfg_shift),
        .relu  (cfg_relu),
        .q     (q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            acc     <= '0;
            acc_sat <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            if (accept && clamp) begin
                acc_sat <= 1'b1;
            end
        end
    end

    // Output FIFO. A push can never hit a full FIFO because accept
    // already requires count < 2.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= q;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_drain_1x1.sv
// tb_psum_drain_1x1: directed and randomized stimulus for psum_drain_1x1,
// with a queue-based scoreboard fed by an arithmetic reference model.
module tb_psum_drain_1x1;
    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic signed [15:0] psum_in = '0;
    logic               psum_valid = 1'b0;
    logic               psum_last = 1'b0;
    logic               psum_ready;
    logic [4:0]         cfg_shift = '0;
    logic               cfg_relu = 1'b0;
    logic signed [7:0]  ofm_out;
    logic               ofm_valid;
    logic               ofm_ready = 1'b1;
    logic               acc_sat;

    psum_drain_1x1 dut (
        .clk        (clk),
        .rstn       (rstn),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .psum_last  (psum_last),
        .psum_ready (psum_ready),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .ofm_out    (ofm_out),
        .ofm_valid  (ofm_valid),
        .ofm_ready  (ofm_ready),
        .acc_sat    (acc_sat)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    longint     m_acc = 0;
    bit         m_sat = 1'b0;
    int         n_accept = 0;
    int         n_pop = 0;
    int         last_accept_cyc = 0;
    int         first_pop_cyc = -1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference requant: add half an LSB of the target scale, floor-divide
    // by 2^shift, optional ReLU, clamp to int8.
    function automatic longint requant_model(input longint s, input int sh, input bit relu);
        longint r;
        r = s;
        if (sh > 0) r = r + (longint'(1) <<< (sh - 1));
        r = r >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic void model_accept(input longint v, input bit last);
        m_acc = m_acc + v;
        if (m_acc > 8388607) begin
            m_acc = 8388607;
            m_sat = 1'b1;
        end else if (m_acc < -8388608) begin
            m_acc = -8388608;
            m_sat = 1'b1;
        end
        if (last) begin
            exp_q.push_back(8'(requant_model(m_acc, int'(cfg_shift), cfg_relu)));
            m_acc = 0;
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rstn && ofm_valid && ofm_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ofm", 1, 0);
            end else begin
                check("ofm_out", longint'(ofm_out), longint'($signed(exp_q.pop_front())));
            end
            n_pop++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic signed [15:0] v, input bit last, output int stalls);
        bit done;
        stalls = 0;
        done = 1'b0;
        psum_valid = 1'b1;
        psum_in = v;
        psum_last = last;
        while (!done && stalls < 500) begin
            @(negedge clk);
            if (psum_ready) begin
                model_accept(longint'(v), last);
                n_accept++;
                last_accept_cyc = cyc;
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 0, 1);
        psum_valid = 1'b0;
        psum_last = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (k != 0) #1;
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        psum_valid = 1'b0;
        psum_last = 1'b0;
        m_acc = 0;
        m_sat = 1'b0;
        exp_q.delete();
        #3;
        check("rst_ofm_valid", ofm_valid, 0);
        check("rst_psum_ready", psum_ready, 1);
        check("rst_acc_sat", acc_sat, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int st;
        bit rand_done;
        rstn = 1'b0;
        #2;
        check("rst_ofm_out", longint'(ofm_out), 0);
        apply_reset();

        // 1: basic accumulation, latency, no stalls
        cfg_shift = 5'd0;
        cfg_relu = 1'b0;
        ofm_ready = 1'b1;
        send_beat(16'sd10, 1'b0, st); check("t1_stall0", st, 0);
        send_beat(16'sd20, 1'b0, st); check("t1_stall1", st, 0);
        send_beat(-16'sd5, 1'b1, st); check("t1_stall2", st, 0);
        check("t1_latency_valid", ofm_valid, 1);
        check("t1_ofm_value", longint'(ofm_out), 25);
        wait_drain();

        // 2: rounding
        cfg_shift = 5'd2;
        send_beat(16'sd6, 1'b1, st);
        send_beat(-16'sd6, 1'b1, st);
        send_beat(16'sd5, 1'b1, st);
        wait_drain();

        // 3: output saturation and ReLU
        cfg_shift = 5'd0;
        send_beat(16'sd100, 1'b0, st);
        send_beat(16'sd100, 1'b1, st);
        send_beat(-16'sd200, 1'b1, st);
        cfg_relu = 1'b1;
        send_beat(-16'sd50, 1'b1, st);
        cfg_relu = 1'b0;
        wait_drain();
        check("t3_acc_sat_clear", acc_sat, 0);

        // 4: backpressure with a full FIFO
        ofm_ready = 1'b0;
        first_pop_cyc = -1;
        begin
            int base_acc;
            base_acc = n_accept;
            fork
                begin
                    send_beat(16'sd1, 1'b1, st);
                    send_beat(16'sd2, 1'b1, st);
                    send_beat(16'sd3, 1'b1, st);
                end
                begin
                    int k;
                    k = 0;
                    while (n_accept < base_acc + 2 && k < 100) begin
                        @(posedge clk);
                        #2;
                        k++;
                    end
                    @(negedge clk);
                    check("t4_ready_low_full", psum_ready, 0);
                    check("t4_valid_full", ofm_valid, 1);
                    check("t4_head_holds", longint'(ofm_out), 1);
                    repeat (3) @(negedge clk);
                    check("t4_still_stalled", n_accept, base_acc + 2);
                    check("t4_head_still", longint'(ofm_out), 1);
                    @(posedge clk);
                    #2;
                    ofm_ready = 1'b1;
                end
            join
            check("t4_accept_after_pop", last_accept_cyc, first_pop_cyc + 1);
        end
        wait_drain();

        // 5: accumulator clamp
        cfg_shift = 5'd16;
        for (int i = 0; i < 512; i++) send_beat(16'sd32767, 1'b0, st);
        send_beat(16'sd0, 1'b1, st);
        wait_drain();
        check("t5_acc_sat", acc_sat, 1);
        check("t5_model_sat", acc_sat, longint'(m_sat));

        // 6: reset in the middle of a group
        cfg_shift = 5'd0;
        send_beat(16'sd5, 1'b0, st);
        send_beat(16'sd5, 1'b0, st);
        apply_reset();
        send_beat(16'sd7, 1'b1, st);
        check("t6_latency_valid", ofm_valid, 1);
        wait_drain();
        check("t6_acc_sat", acc_sat, 0);

        // 7: randomized groups with random backpressure and idle gaps
        rand_done = 1'b0;
        fork
            begin
                for (int g = 0; g < 40; g++) begin
                    int nb;
                    cfg_shift = 5'($urandom_range(0, 12));
                    cfg_relu = 1'($urandom_range(0, 1));
                    nb = $urandom_range(1, 6);
                    for (int b = 0; b < nb; b++) begin
                        logic signed [15:0] v;
                        v = 16'($urandom());
                        if ($urandom_range(0, 3) == 0) v = 16'($urandom_range(0, 200)) - 16'sd100;
                        send_beat(v, b == nb - 1, st);
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2;
                    ofm_ready = 1'($urandom_range(0, 1));
                end
                ofm_ready = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        wait_drain();
        check("t7_acc_sat_model", acc_sat, longint'(m_sat));
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
